cdr_lock_controller: RTL and testbench

Word-alignment and lock controller that sits after the `cdr_data_recovery` deserializer in the aclk domain. It searches the recovered word stream for a periodic sync word at every bit offset and re-aligns the stream to the offset it finds. A hunt/verify/locked state machine decides when the link is locked. If no sync word is found in time, the controller holds the CDR datapath in reset and retries.

---
 rtl/cdr_pkg.sv | 5 +
 rtl/cdr_sync_matcher.sv | 20 ++
 rtl/cdr_lock_controller.sv | 169 ++++++++++++++++
 tb/tb_cdr_lock_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// cdr_pkg: shared lock-state encoding and default sync pattern for the CDR lock controller.
package cdr_pkg;
  typedef enum logic [1:0] {RESYNC, HUNT, VERIFY, LOCKED} t_lock_state;
  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;
endpackage

// File: rtl/cdr_sync_matcher.sv
// cdr_sync_matcher: compares every bit-offset candidate of a two-word window against the sync word.
module cdr_sync_matcher #(
  parameter int W = 8
) (
  input  logic [2*W-2:0]         win,
  input  logic [W-1:0]           sync_word,
  output logic [W-1:0]           match,
  output logic [$clog2(W)-1:0]   offset,
  output logic                   hit
);
  always_comb begin
    match  = '0;
    offset = '0;
    for (int k = W - 1; k >= 0; k--) begin
      match[k] = win[k +: W] == sync_word;
      offset   = match[k] ? $clog2(W)'(k) : offset;
    end
    hit = |match;
  end
endmodule

// File: rtl/cdr_lock_controller.sv
// cdr_lock_controller: sync-word hunt/verify/lock FSM with bit re-alignment and CDR resync control.
// Define CDR_LOCK_STRIP_SYNC_EN to drop sync words from the aligned output while locked.
module cdr_lock_controller
  import cdr_pkg::*;
#(
  parameter int                     TDATA_WIDTH   = 8,
  parameter logic [TDATA_WIDTH-1:0] SYNC_WORD     = TDATA_WIDTH'(SYNC_WORD_DEFAULT),
  parameter int                     SYNC_PERIOD   = 16,
  parameter int                     LOCK_COUNT    = 4,
  parameter int                     UNLOCK_COUNT  = 3,
  parameter int                     HUNT_TIMEOUT  = 1024,
  parameter int                     RESYNC_CYCLES = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           s_tvalid,
  input  logic [TDATA_WIDTH-1:0]         s_tdata,
  output logic                           cdr_rst_n,
  output logic                           m_tvalid,
  output logic [TDATA_WIDTH-1:0]         m_tdata,
  output logic                           locked,
  output logic [$clog2(TDATA_WIDTH)-1:0] align_offset,
  output logic [7:0]                     resync_count
);
  localparam int OW   = $clog2(TDATA_WIDTH);
  localparam int PW   = $clog2(SYNC_PERIOD);
  localparam int TMAX = HUNT_TIMEOUT > RESYNC_CYCLES ? HUNT_TIMEOUT : RESYNC_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int GW   = $clog2(LOCK_COUNT + 1);
  localparam int BW   = $clog2(UNLOCK_COUNT + 1);

  t_lock_state            state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [TDATA_WIDTH-1:0] prev_word_q, prev_word_d;
  logic                   prev_valid_q, prev_valid_d;
  logic [PW-1:0]          word_pos_q, word_pos_d;
  logic [GW-1:0]          good_q, good_d;
  logic [BW-1:0]          bad_q, bad_d;
  logic [OW-1:0]          align_q, align_d;
  logic [7:0]             resync_count_q, resync_count_d;
  logic                   cdr_rst_n_q, cdr_rst_n_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;

  logic [2*TDATA_WIDTH-1:0] win;
  logic [TDATA_WIDTH-1:0]   match_vec, cand;
  logic [OW-1:0]            hit_off;
  logic                     hit, beat, wrap, chk, aligned_hit, strip;

  assign win         = {s_tdata, prev_word_q};
  assign cand        = TDATA_WIDTH'(win >> align_q);
  assign beat        = s_tvalid && state_q != RESYNC;
  assign wrap        = beat && word_pos_q == PW'(SYNC_PERIOD - 1);
  assign chk         = wrap && prev_valid_q;
  assign aligned_hit = match_vec[align_q];
`ifdef CDR_LOCK_STRIP_SYNC_EN
  assign strip = wrap;
`else
  assign strip = 1'b0;
`endif

  cdr_sync_matcher #(.W(TDATA_WIDTH)) u_matcher (
    .win       (win[2*TDATA_WIDTH-2:0]),
    .sync_word (SYNC_WORD),
    .match     (match_vec),
    .offset    (hit_off),
    .hit       (hit)
  );

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    prev_word_d    = prev_word_q;
    prev_valid_d   = prev_valid_q;
    word_pos_d     = word_pos_q;
    good_d         = good_q;
    bad_d          = bad_q;
    align_d        = align_q;
    resync_count_d = resync_count_q;
    m_tvalid_d     = state_q == LOCKED && s_tvalid && !strip;
    m_tdata_d      = m_tvalid_d ? cand : m_tdata_q;
    if (beat) begin
      prev_word_d  = s_tdata;
      prev_valid_d = 1'b1;
      word_pos_d   = wrap ? '0 : word_pos_q + 1'b1;
    end
    case (state_q)
      RESYNC: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(RESYNC_CYCLES - 1)) begin
          state_d = HUNT;
          timer_d = '0;
        end
      end
      HUNT:
        if (beat && prev_valid_q && hit) begin
          align_d    = hit_off;
          good_d     = GW'(1);
          bad_d      = '0;
          word_pos_d = '0;
          state_d    = LOCK_COUNT == 1 ? LOCKED : VERIFY;
        end else if (timer_q == TW'(HUNT_TIMEOUT - 1)) begin
          // resync throws away the partial window so the next hunt starts clean
          state_d        = RESYNC;
          timer_d        = '0;
          prev_word_d    = '0;
          prev_valid_d   = 1'b0;
          resync_count_d = resync_count_q + 8'(resync_count_q != 8'hFF);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      VERIFY:
        if (chk && aligned_hit) begin
          good_d  = good_q + 1'b1;
          state_d = good_q == GW'(LOCK_COUNT - 1) ? LOCKED : VERIFY;
        end else if (chk) begin
          state_d = HUNT;
          timer_d = '0;
        end
      LOCKED:
        if (chk && aligned_hit) begin
          bad_d = '0;
        end else if (chk) begin
          bad_d = bad_q + 1'b1;
          if (bad_q == BW'(UNLOCK_COUNT - 1)) begin
            state_d = HUNT;
            timer_d = '0;
          end
        end
    endcase
    cdr_rst_n_d = state_d != RESYNC;
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q        <= RESYNC;
      timer_q        <= '0;
      prev_word_q    <= '0;
      prev_valid_q   <= 1'b0;
      word_pos_q     <= '0;
      good_q         <= '0;
      bad_q          <= '0;
      align_q        <= '0;
      resync_count_q <= '0;
      cdr_rst_n_q    <= 1'b0;
      m_tvalid_q     <= 1'b0;
      m_tdata_q      <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      prev_word_q    <= prev_word_d;
      prev_valid_q   <= prev_valid_d;
      word_pos_q     <= word_pos_d;
      good_q         <= good_d;
      bad_q          <= bad_d;
      align_q        <= align_d;
      resync_count_q <= resync_count_d;
      cdr_rst_n_q    <= cdr_rst_n_d;
      m_tvalid_q     <= m_tvalid_d;
      m_tdata_q      <= m_tdata_d;
    end

  assign cdr_rst_n    = cdr_rst_n_q;
  assign m_tvalid     = m_tvalid_q;
  assign m_tdata      = m_tdata_q;
  assign locked       = state_q == LOCKED;
  assign align_offset = align_q;
  assign resync_count = resync_count_q;
endmodule

// File: tb/tb_cdr_lock_controller.sv
// tb_cdr_lock_controller: randomized and directed checks of cdr_lock_controller against a behavioural model.
module tb_cdr_lock_controller;
  localparam int W = 8, P = 4, LC = 3, UC = 2, HT = 64, RC = 8;
  localparam logic [7:0] SW = 8'hBC;
`ifdef CDR_LOCK_STRIP_SYNC_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic       aclk = 1'b0, aresetn = 1'b0, s_tvalid = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       cdr_rst_n, m_tvalid, locked;
  logic [7:0] m_tdata, resync_count;
  logic [2:0] align_offset;

  int n_chk = 0, n_fail = 0;

  always #5 aclk = ~aclk;

  cdr_lock_controller #(
    .TDATA_WIDTH(W), .SYNC_WORD(SW), .SYNC_PERIOD(P), .LOCK_COUNT(LC),
    .UNLOCK_COUNT(UC), .HUNT_TIMEOUT(HT), .RESYNC_CYCLES(RC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .cdr_rst_n(cdr_rst_n), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .locked(locked),
    .align_offset(align_offset), .resync_count(resync_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cand(input logic [15:0] w, input int k);
    return 8'(w >> k);
  endfunction

  // Behavioural model: the link state as plain variables updated from the rules each clock.
  string      m_st = "RESYNC";
  int         m_spent = 0, m_pos = 0, m_good = 0, m_bad = 0, m_align = 0, m_rc = 0, fk;
  logic [7:0] m_prev = '0, m_md = '0;
  logic [15:0] w;
  bit         m_pv = 0, m_rstn = 0, m_mv = 0, wrap, chk, hit_al, found, go_rs;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_st = "RESYNC"; m_spent = 0; m_pos = 0; m_good = 0; m_bad = 0; m_align = 0;
      m_rc = 0; m_prev = '0; m_md = '0; m_pv = 0; m_rstn = 0; m_mv = 0;
    end else if (m_st == "RESYNC") begin
      m_mv = 0;
      m_spent++;
      if (m_spent == RC) begin m_st = "HUNT"; m_spent = 0; m_rstn = 1; end
    end else begin
      w      = {s_tdata, m_prev};
      wrap   = s_tvalid && ((m_pos + 1) % P == 0);
      chk    = wrap && m_pv;
      hit_al = cand(w, m_align) == SW;
      m_mv   = (m_st == "LOCKED") && s_tvalid && !(STRIP && wrap);
      if (m_mv) m_md = cand(w, m_align);
      found = 0; fk = 0;
      for (int k = W - 1; k >= 0; k--) if (cand(w, k) == SW) begin found = 1; fk = k; end
      if (s_tvalid) m_pos = (m_pos + 1) % P;
      go_rs = 0;
      if (m_st == "HUNT") begin
        if (s_tvalid && m_pv && found) begin
          m_align = fk; m_good = 1; m_bad = 0; m_pos = 0;
          if (LC == 1) m_st = "LOCKED"; else m_st = "VERIFY";
        end else begin
          m_spent++;
          go_rs = m_spent == HT;
        end
      end else if (m_st == "VERIFY") begin
        if (chk && hit_al) begin
          m_good++;
          if (m_good == LC) begin m_st = "LOCKED"; m_bad = 0; end
        end else if (chk) begin
          m_st = "HUNT"; m_spent = 0;
        end
      end else if (chk) begin
        if (hit_al) m_bad = 0;
        else begin
          m_bad++;
          if (m_bad == UC) begin m_st = "HUNT"; m_spent = 0; end
        end
      end
      if (s_tvalid) begin m_prev = s_tdata; m_pv = 1; end
      if (go_rs) begin
        m_st = "RESYNC"; m_spent = 0; m_prev = '0; m_pv = 0; m_rstn = 0;
        m_rc = (m_rc < 255) ? m_rc + 1 : 255;
      end
    end
  end

  // Transmit-side bookkeeping: the word that offset 3 must recover on each beat.
  logic [7:0] last_tx = '0, exp_fwd = '0, exp_q = '0;
  bit         want_first = 0;

  always @(posedge aclk) exp_q <= exp_fwd;

  always @(negedge aclk) begin
    check("cdr_rst_n", cdr_rst_n, m_rstn);
    check("locked", locked, m_st == "LOCKED");
    check("align_offset", align_offset, m_align);
    check("resync_count", resync_count, m_rc);
    check("m_tvalid", m_tvalid, m_mv);
    if (m_mv) check("m_tdata", m_tdata, m_md);
    if (want_first && m_tvalid) begin
      check("first_fwd", m_tdata, exp_q);
      want_first = 0;
    end
  end

  function automatic logic [7:0] payload();
    logic [7:0] r = 8'($urandom);
    return r & ($urandom_range(0, 1) ? 8'h55 : 8'hAA);
  endfunction

  task automatic beat(input logic [7:0] tx);
    s_tvalid = 1'b1;
    s_tdata  = {tx[4:0], last_tx[7:5]};
    exp_fwd  = last_tx;
    last_tx  = tx;
    @(negedge aclk);
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    @(negedge aclk);
  endtask

  task automatic frame(input bit sync_ok, input int gap_pct);
    for (int i = 0; i < P; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle();
      beat((i == 0 && sync_ok) ? SW : payload());
    end
  endtask

  task automatic async_reset();
    #2 aresetn = 1'b0;
    #1;
    check("arst_cdr_rst_n", cdr_rst_n, 0);
    check("arst_locked", locked, 0);
    check("arst_align", align_offset, 0);
    check("arst_m_tvalid", m_tvalid, 0);
    s_tvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic wait_hunt();
    int n = 0;
    while (cdr_rst_n !== 1'b1 && n < 40) begin idle(); n++; end
    check("wait_hunt", cdr_rst_n, 1);
  endtask

  initial begin
    int fwd_cnt, bc_cnt;
    repeat (3) @(negedge aclk);
    check("rst_cdr_rst_n", cdr_rst_n, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_locked", locked, 0);
    check("rst_align", align_offset, 0);
    check("rst_resync_count", resync_count, 0);
    aresetn = 1'b1;
    for (int i = 0; i < RC - 1; i++) begin idle(); check("resync_low", cdr_rst_n, 0); end
    idle();
    check("resync_release", cdr_rst_n, 1);
    check("first_resync_not_counted", resync_count, 0);

    // lock acquisition at bit offset 3
    want_first = 1;
    repeat (5) frame(1, 0);
    check("lock_locked", locked, 1);
    check("lock_align", align_offset, 3);
    check("first_fwd_seen", want_first, 0);
    fwd_cnt = 0; bc_cnt = 0;
    for (int i = 0; i < 2 * P; i++) begin
      beat(i % P == 0 ? SW : payload());
      fwd_cnt += int'(m_tvalid);
      bc_cnt  += int'(m_tvalid && m_tdata == SW);
    end
    check("fwd_per_2_frames", fwd_cnt, STRIP ? 6 : 8);
    check("sync_on_output", bc_cnt, STRIP ? 0 : 2);

    // lock loss: single miss survives, two in a row drop
    frame(1, 0); frame(0, 0); frame(1, 0);
    idle();
    check("single_miss_keeps_lock", locked, 1);
    frame(0, 0); frame(0, 0);
    idle();
    check("double_miss_drops_lock", locked, 0);

    // false lock from a single stray sync word
    frame(0, 0); frame(1, 0); frame(0, 0); frame(0, 0);
    idle();
    check("false_lock_locked", locked, 0);
    check("false_lock_align", align_offset, 3);

    // relock, then asynchronous reset mid-frame
    repeat (5) frame(1, 0);
    check("relock", locked, 1);
    s_tvalid = 1'b1;
    s_tdata  = 8'h3C;
    async_reset();
    wait_hunt();

    // hunt timeout and resync counter saturation
    for (int i = 0; i < HT - 1; i++) beat(payload());
    check("hunt_before_timeout", cdr_rst_n, 1);
    beat(payload());
    check("timeout_resync", cdr_rst_n, 0);
    check("timeout_count", resync_count, 1);
    for (int i = 0; i < RC - 1; i++) idle();
    check("timeout_resync_held", cdr_rst_n, 0);
    idle();
    check("timeout_resync_done", cdr_rst_n, 1);
    for (int i = 0; i < 256 * (HT + RC) + 100; i++) idle();
    check("resync_saturate", resync_count, 255);

    // randomized traffic against the model
    async_reset();
    for (int a = 0; a < 700; a++) begin
      int r = $urandom_range(0, 99);
      if (r < 80) frame($urandom_range(0, 9) != 0, 15);
      else if (r < 90) repeat ($urandom_range(1, 90)) idle();
      else if (r < 99) begin
        last_tx = 8'($urandom);
        s_tvalid = 1'b1;
        s_tdata  = 8'($urandom);
        @(negedge aclk);
      end else async_reset();
    end
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
